// File: rtl/vend_dispense_ctrl.sv
// Vending machine actuator sequencer: turns one vend request into an item
// solenoid pulse followed by one coin-ejector pulse per quarter of change.
module vend_dispense_ctrl #(
    parameter int unsigned PULSE_CYCLES = 2_500_000,
    parameter int unsigned GAP_CYCLES   = 2_500_000
) (
    input  logic       CLK50,
    input  logic       RES,
    input  logic       vend_valid,
    input  logic       T,
    input  logic [1:0] C,
    output logic       item_sol,
    output logic       coin_sol,
    output logic       busy,
    output logic       done,
    output logic [1:0] coins_left,
    output logic [7:0] sales_cnt,
    output logic       overrun
);

    localparam int unsigned MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ITEM_ON  = 3'd1,
        ITEM_GAP = 3'd2,
        COIN_ON  = 3'd3,
        COIN_GAP = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [1:0]    coins_nxt;
    logic [7:0]    sales_nxt;
    logic          overrun_nxt;
    logic          expired;

    assign expired = (timer == '0);

    // State, timer, counters and solenoid drives; outputs decode next state so
    // they change on the same edge as the state register.
    always_ff @(posedge CLK50) begin
        if (RES) begin
            state      <= IDLE;
            timer      <= '0;
            coins_left <= 2'd0;
            sales_cnt  <= 8'd0;
            overrun    <= 1'b0;
            item_sol   <= 1'b0;
            coin_sol   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            coins_left <= coins_nxt;
            sales_cnt  <= sales_nxt;
            overrun    <= overrun_nxt;
            item_sol   <= (state_nxt == ITEM_ON);
            coin_sol   <= (state_nxt == COIN_ON);
            busy       <= (state_nxt != IDLE);
            done       <= (state_nxt == DONE);
        end
    end

    // Next-state, timer reload and counter updates.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        coins_nxt   = coins_left;
        sales_nxt   = sales_cnt;
        overrun_nxt = overrun;

        // No queue: any request outside IDLE is dropped and remembered.
        if (vend_valid && (state != IDLE)) begin
            overrun_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (vend_valid) begin
                    if (T) begin
                        state_nxt = ITEM_ON;
                        timer_nxt = PULSE_LOAD;
                        coins_nxt = C;
                    end else if (C != 2'd0) begin
                        state_nxt = COIN_ON;
                        timer_nxt = PULSE_LOAD;
                        coins_nxt = C;
                    end
                end
            end
            ITEM_ON: begin
                if (expired) begin
                    state_nxt = ITEM_GAP;
                    timer_nxt = GAP_LOAD;
                    if (sales_cnt != 8'hFF) begin
                        sales_nxt = sales_cnt + 8'd1;
                    end
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            ITEM_GAP, COIN_GAP: begin
                if (expired) begin
                    if (coins_left != 2'd0) begin
                        state_nxt = COIN_ON;
                        timer_nxt = PULSE_LOAD;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            COIN_ON: begin
                if (expired) begin
                    state_nxt = COIN_GAP;
                    timer_nxt = GAP_LOAD;
                    coins_nxt = coins_left - 2'd1;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl with PULSE_CYCLES=4, GAP_CYCLES=3.
module tb_vend_dispense_ctrl;

    logic       CLK50 = 1'b0;
    logic       RES;
    logic       vend_valid;
    logic       T;
    logic [1:0] C;
    logic       item_sol;
    logic       coin_sol;
    logic       busy;
    logic       done;
    logic [1:0] coins_left;
    logic [7:0] sales_cnt;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    vend_dispense_ctrl #(
        .PULSE_CYCLES(4),
        .GAP_CYCLES  (3)
    ) dut (
        .CLK50     (CLK50),
        .RES       (RES),
        .vend_valid(vend_valid),
        .T         (T),
        .C         (C),
        .item_sol  (item_sol),
        .coin_sol  (coin_sol),
        .busy      (busy),
        .done      (done),
        .coins_left(coins_left),
        .sales_cnt (sales_cnt),
        .overrun   (overrun)
    );

    always #5 CLK50 = ~CLK50;

    typedef struct {
        logic       t;
        logic [1:0] c;
        int         drop_at;
        int         exp_busy;
        int         exp_item;
        int         exp_coin;
        int         exp_pulses;
        int         exp_sales;
        int         exp_ovr;
    } vec_t;

    localparam int NV = 8;
    vec_t vec [NV];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK50);
        #1;
    endtask

    task automatic do_reset();
        RES        = 1'b1;
        vend_valid = 1'b0;
        T          = 1'b0;
        C          = 2'd0;
        tick();
        tick();
        RES = 1'b0;
    endtask

    // Issue one request, then watch the busy window; drop_at injects an extra
    // request at that busy-cycle index (-1 = none).
    task automatic run_vend(input logic t, input logic [1:0] c, input int drop_at,
                            output int blen, output int icyc, output int ccyc,
                            output int npulse, output int ndone, output int novl,
                            output int bad_coins, output int done_last);
        logic prev_coin;
        vend_valid = 1'b1;
        T          = t;
        C          = c;
        tick();
        vend_valid = 1'b0;
        blen = 0; icyc = 0; ccyc = 0; npulse = 0; ndone = 0; novl = 0;
        bad_coins = 0; done_last = 0; prev_coin = 1'b0;
        for (int k = 0; k < 400 && busy; k++) begin
            blen++;
            if (item_sol) icyc++;
            if (coin_sol) begin
                ccyc++;
                if (!prev_coin) begin
                    if (int'(coins_left) != int'(c) - npulse) bad_coins++;
                    npulse++;
                end
            end
            if (done) ndone++;
            done_last = int'(done);
            if (item_sol && coin_sol) novl++;
            prev_coin  = coin_sol;
            vend_valid = (k == drop_at);
            T          = 1'b1;
            C          = 2'd3;
            tick();
        end
        vend_valid = 1'b0;
    endtask

    initial begin
        int blen, icyc, ccyc, npulse, ndone, novl, bad_coins, done_last;

        //          t  c   drop busy item coin pulses sales ovr
        vec[0] = '{1'b1, 2'd0, -1,  8, 4,  0, 0, 1, 0};
        vec[1] = '{1'b1, 2'd3, -1, 29, 4, 12, 3, 1, 0};
        vec[2] = '{1'b0, 2'd2, -1, 15, 0,  8, 2, 0, 0};
        vec[3] = '{1'b0, 2'd1, -1,  8, 0,  4, 1, 0, 0};
        vec[4] = '{1'b1, 2'd1, -1, 15, 4,  4, 1, 1, 0};
        vec[5] = '{1'b1, 2'd0,  3,  8, 4,  0, 0, 1, 1};
        vec[6] = '{1'b1, 2'd0,  7,  8, 4,  0, 0, 1, 1};
        vec[7] = '{1'b0, 2'd3, 14, 22, 0, 12, 3, 0, 1};

        do_reset();
        check("rst item_sol",   int'(item_sol),   0);
        check("rst coin_sol",   int'(coin_sol),   0);
        check("rst busy",       int'(busy),       0);
        check("rst done",       int'(done),       0);
        check("rst coins_left", int'(coins_left), 0);
        check("rst sales_cnt",  int'(sales_cnt),  0);
        check("rst overrun",    int'(overrun),    0);

        for (int i = 0; i < NV; i++) begin
            do_reset();
            run_vend(vec[i].t, vec[i].c, vec[i].drop_at, blen, icyc, ccyc,
                     npulse, ndone, novl, bad_coins, done_last);
            check($sformatf("row%0d busy_len", i),    blen,      vec[i].exp_busy);
            check($sformatf("row%0d item_cycles", i), icyc,      vec[i].exp_item);
            check($sformatf("row%0d coin_cycles", i), ccyc,      vec[i].exp_coin);
            check($sformatf("row%0d coin_pulses", i), npulse,    vec[i].exp_pulses);
            check($sformatf("row%0d coins_step", i),  bad_coins, 0);
            check($sformatf("row%0d done_count", i),  ndone,     1);
            check($sformatf("row%0d done_last", i),   done_last, 1);
            check($sformatf("row%0d overlap", i),     novl,      0);
            check($sformatf("row%0d done_after", i),  int'(done), 0);
            check($sformatf("row%0d coins_end", i),   int'(coins_left), 0);
            check($sformatf("row%0d sales", i),       int'(sales_cnt), vec[i].exp_sales);
            check($sformatf("row%0d overrun", i),     int'(overrun), vec[i].exp_ovr);
            tick();
            check($sformatf("row%0d idle_after", i),  int'(busy), 0);
        end

        // T=0, C=0 is ignored entirely.
        do_reset();
        vend_valid = 1'b1;
        T          = 1'b0;
        C          = 2'd0;
        tick();
        vend_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("null busy%0d", k), int'(busy), 0);
            check($sformatf("null done%0d", k), int'(done), 0);
            tick();
        end
        check("null overrun", int'(overrun), 0);

        // Reset in the second cycle of the first COIN_ON of a T=1, C=2 vend.
        do_reset();
        vend_valid = 1'b1;
        T          = 1'b1;
        C          = 2'd2;
        tick();
        vend_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("midrst coin_sol_pre",   int'(coin_sol),   1);
        check("midrst coins_left_pre", int'(coins_left), 2);
        check("midrst sales_pre",      int'(sales_cnt),  1);
        RES = 1'b1;
        tick();
        check("midrst coin_sol",   int'(coin_sol),   0);
        check("midrst busy",       int'(busy),       0);
        check("midrst coins_left", int'(coins_left), 0);
        check("midrst sales",      int'(sales_cnt),  0);
        check("midrst done",       int'(done),       0);
        RES = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("midrst idle%0d", k), int'(busy | done), 0);
        end

        // Back-to-back item vends saturate the sales counter.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_vend(1'b1, 2'd0, -1, blen, icyc, ccyc, npulse, ndone, novl,
                     bad_coins, done_last);
            if (i == 0 || i == 254 || i == 255) begin
                check($sformatf("sat busy_len%0d", i), blen, 8);
            end
            if (i == 254) check("sat sales_at_255", int'(sales_cnt), 255);
        end
        check("sat sales_hold", int'(sales_cnt), 255);
        check("sat overrun",    int'(overrun),   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
